serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b - bin, LSB first, one bit per clock.
- A single full-subtractor cell and a borrow flop do the arithmetic.
- Operands load in parallel on a start/ready handshake. The result is returned in parallel with a one-cycle done pulse.
- Area-lean arithmetic unit for the adder/subtractor datapath. It is the subtract-direction sequential counterpart to the full_adder cell.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- CW, $clog2(WIDTH), bit-counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- bin  input  1  borrow-in; sampled on the accepting edge.
- ready  output  1  high in IDLE; combinational decode of state.
- diff  output  WIDTH  result, (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned).
- done  output  1  one-cycle pulse when diff/bout become valid.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, internal A/B/D shift regs=0, borrow flop=0, diff=0, bout=0, done=0. ready=1 while in IDLE, including during reset.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: load A<=a, B<=b, br<=bin, cnt<=0, state<=SHIFT.
  - start=0: stay in IDLE; diff/bout hold their last values.
- SHIFT (edges E1..E_WIDTH), one bit per edge:
  - d = A[0]^B[0]^br.
  - br <= (~A[0]&B[0]) | (~(A[0]^B[0])&br).
  - D <= {d, D[WIDTH-1:1]}; A,B shift right by 1 (zero fill); cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge (edge E_WIDTH): state<=DONE, diff<=final D including this bit, bout<=final br, done<=1.
- DONE: lasts exactly one cycle (done=1, ready=0). Next edge: done<=0, state<=IDLE.
- Latency: done is high in the cycle between edges E_WIDTH and E_WIDTH+1. ready returns high after E_WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while ready=0 (SHIFT or DONE): ignored. No effect on the in-flight operation; not queued.
- start held high continuously: a new operation is accepted on the first edge back in IDLE (E_WIDTH+2 relative to the previous E0).
- diff/bout update only at E_WIDTH. They are stable from done until the next operation's E_WIDTH. They do not change during SHIFT of a subsequent operation.
- a/b/bin changing after E0: no effect on the result.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values. Partial results are discarded and no done pulse is produced.
- Counter must not wrap past WIDTH-1. Exit to DONE is decided on cnt==WIDTH-1, so the count is correct for non-power-of-2 WIDTH.
- Arithmetic check (all cases): {bout,diff} == ({1'b0,a} - {1'b0,b} - bin) taken modulo 2^(WIDTH+1), with bout taken as the inverted carry.

Test Plan:
- WIDTH=8, a=5, b=3, bin=0, start at E0 -> done only in the cycle after E8; diff=8'h02, bout=0; ready=0 from E0 to E9.
- a=3, b=5, bin=0 -> diff=8'hFE, bout=1. Then a=0, b=0, bin=1 -> diff=8'hFF, bout=1. Then a=8'hFF, b=8'hFF, bin=0 -> diff=8'h00, bout=0.
- Start a=8'h80, b=8'h01; pulse start with a=8'h11, b=8'h22 at E3 (mid-SHIFT) -> ignored; result diff=8'h7F, bout=0; exactly one done pulse.
- Start a=8'h40, b=8'h10; assert rst asynchronously between E4 and E5 -> diff=0, bout=0, done=0, ready=1 immediately; no done pulse afterwards.
- Hold start=1 continuously with a=10, b=4 -> done pulses every 10 cycles, each with diff=6, bout=0; diff never glitches between pulses.
- Random sweep (WIDTH=8 and WIDTH=5), 1000 operands -> {bout,diff} matches the arithmetic-check model every time.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// One full-subtractor cell plus a borrow flop; parallel load and parallel result.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] sh_q;
  logic             br_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             bit_d;
  logic             br_d;
  logic [WIDTH-1:0] shifted;
  logic             last;

  // Full-subtractor cell; sh_q holds the WIDTH-1 result bits produced so far.
  always_comb begin
    bit_d   = a_q[0] ^ b_q[0] ^ br_q;
    br_d    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    shifted = {bit_d, sh_q};
    last    = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready = (state_q == StIdle);
    done  = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sh_q   <= '0;
      br_q   <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= bin;
            cnt_q <= '0;
          end
        end
        StShift: begin
          br_q  <= br_d;
          sh_q  <= shifted[WIDTH-1:1];
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          // Result registers move only on the final bit so they stay stable across later ops.
          if (last) begin
            diff_q <= shifted;
            bout_q <= br_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, corner sequences,
// and a randomized sweep at WIDTH=8 and WIDTH=5 against an arithmetic model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, bout8, done8;
  logic [7:0] diff8;
  logic       start5 = 1'b0, bin5 = 1'b0;
  logic [4:0] a5 = '0, b5 = '0;
  logic       ready5, bout5, done5;
  logic [4:0] diff5;

  int checks = 0;
  int failures = 0;
  int done_cnt8 = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .ready(ready8), .diff(diff8), .bout(bout8), .done(done8)
  );

  serial_subtractor #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5), .bin(bin5),
    .ready(ready5), .diff(diff5), .bout(bout5), .done(done5)
  );

  always @(negedge clk) if (done8) done_cnt8++;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One operation on the selected DUT; returns result, edges to done, and handshake status.
  task automatic run(input bit sel, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                     output logic [7:0] dv, output logic bo, output int lat,
                     output bit busy_ok, output bit post_ok);
    @(negedge clk);
    if (sel) begin a5 = av[4:0]; b5 = bv[4:0]; bin5 = bi; start5 = 1'b1; end
    else     begin a8 = av;      b8 = bv;      bin8 = bi; start8 = 1'b1; end
    @(posedge clk); #1;
    start5 = 1'b0; start8 = 1'b0;
    // Scramble inputs after acceptance; must not affect the result.
    a8 = ~av; b8 = ~bv; bin8 = ~bi; a5 = ~av[4:0]; b5 = ~bv[4:0]; bin5 = ~bi;
    lat = 0;
    busy_ok = 1'b1;
    while (!(sel ? done5 : done8) && lat < 30) begin
      if (sel ? ready5 : ready8) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (sel ? ready5 : ready8) busy_ok = 1'b0;
    dv = sel ? {3'b000, diff5} : diff8;
    bo = sel ? bout5 : bout8;
    @(posedge clk); #1;
    post_ok = sel ? (ready5 && !done5) : (ready8 && !done8);
  endtask

  initial begin
    vec_t       tbl[$];
    logic [7:0] dv, prevd;
    logic       bo;
    int         lat, base, r, w, pulses[$];
    bit         busy_ok, post_ok, glitch;
    logic [7:0] ra, rb;
    logic       rbi;
    logic [8:0] model;

    tbl.push_back('{8'h05, 8'h03, 1'b0, 8'h02, 1'b0});
    tbl.push_back('{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1});
    tbl.push_back('{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1});
    tbl.push_back('{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{8'hFF, 8'hFE, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1});
    tbl.push_back('{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0});

    // Reset state, including ready high while reset is asserted.
    #12;
    chk("rst_ready", ready8, 1);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_bout", bout8, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_hold_ready", ready8, 1);

    foreach (tbl[i]) begin
      run(1'b0, tbl[i].a, tbl[i].b, tbl[i].bin, dv, bo, lat, busy_ok, post_ok);
      chk($sformatf("tbl%0d_diff", i), dv, tbl[i].diff);
      chk($sformatf("tbl%0d_bout", i), bo, tbl[i].bout);
      chk($sformatf("tbl%0d_latency", i), lat, 8);
      chk($sformatf("tbl%0d_ready_low", i), busy_ok, 1);
      chk($sformatf("tbl%0d_back_idle", i), post_ok, 1);
    end

    // Start pulse mid-SHIFT is ignored; exactly one done.
    base = done_cnt8;
    @(negedge clk); a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (2) @(posedge clk);
    #1; a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 30) begin @(posedge clk); #1; lat++; end
    chk("ignore_diff", diff8, 8'h7F);
    chk("ignore_bout", bout8, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("ignore_one_done", done_cnt8 - base, 1);
    chk("ignore_idle", ready8, 1);

    // Asynchronous reset between E4 and E5.
    base = done_cnt8;
    @(negedge clk); a8 = 8'h40; b8 = 8'h10; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3; rst = 1'b1;
    #1;
    chk("arst_diff", diff8, 0);
    chk("arst_bout", bout8, 0);
    chk("arst_done", done8, 0);
    chk("arst_ready", ready8, 1);
    @(negedge clk); rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("arst_no_done", done_cnt8 - base, 0);
    chk("arst_diff_after", diff8, 0);

    // start held high: back-to-back ops every WIDTH+2 cycles, diff steady between pulses.
    glitch = 1'b0;
    prevd = diff8;
    @(negedge clk); a8 = 8'd10; b8 = 8'd4; bin8 = 1'b0; start8 = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (done8) begin
        pulses.push_back(c);
        chk("cont_diff", diff8, 8'd6);
        chk("cont_bout", bout8, 0);
      end else if (diff8 !== prevd) begin
        glitch = 1'b1;
      end
      prevd = diff8;
    end
    start8 = 1'b0;
    chk("cont_no_glitch", glitch, 0);
    chk("cont_pulses", pulses.size(), 4);
    if (pulses.size() >= 2) begin
      chk("cont_first", pulses[0], 8);
      for (int k = 1; k < pulses.size(); k++)
        chk($sformatf("cont_gap%0d", k), pulses[k] - pulses[k-1], 10);
    end
    repeat (12) @(posedge clk);

    // Randomized sweep against plain integer arithmetic.
    for (int s = 0; s < 2; s++) begin
      w = s ? 5 : 8;
      for (int n = 0; n < 500; n++) begin
        ra  = 8'($urandom_range(0, (1 << w) - 1));
        rb  = 8'($urandom_range(0, (1 << w) - 1));
        rbi = 1'($urandom_range(0, 1));
        if (n == 0) begin ra = '0; rb = 8'((1 << w) - 1); rbi = 1'b1; end
        run(s[0], ra, rb, rbi, dv, bo, lat, busy_ok, post_ok);
        r = int'(ra) - int'(rb) - int'(rbi);
        model = 9'(r & ((1 << (w + 1)) - 1));
        chk($sformatf("rnd_w%0d_%0d_%0h_%0h_%0d", w, n, ra, rb, rbi),
            {23'b0, bo, dv}, {23'b0, model[w], (s != 0) ? {3'b000, model[4:0]} : model[7:0]});
        chk($sformatf("rnd_w%0d_%0d_borrow_rule", w, n), bo, (r < 0) ? 1 : 0);
        chk($sformatf("rnd_w%0d_%0d_timing", w, n), {lat, busy_ok, post_ok}, {w, 2'b11});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
